// File: rtl/iic_target.sv
// iic_target: I2C target (responder) with START/STOP decode, 7-bit address match
// and pointer-plus-data register writes into an external 256x8 register file.
// Optional register reads (including repeated-START reads) are compiled in when
// the macro IIC_TARGET_READ_EN is defined; the default build is write-only.
module iic_target #(
    parameter logic [6:0]  SLAVE_ADDR = 7'b1110110,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_en,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic [7:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_busy
);

    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_IGNORE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_WDATA, S_WDATA_ACK
`ifdef IIC_TARGET_READ_EN
        , S_RDATA, S_RDATA_ACK
`endif
    } state_t;

    logic [1:0] r_scl_sync, r_sda_sync;
    logic [3:0] r_scl_cnt, r_sda_cnt;
    logic       r_scl_f, r_sda_f, r_scl_d, r_sda_d;
    state_t     r_state;
    logic [2:0] r_bitcnt;
    logic [6:0] r_shift;
    logic       r_ack_on;
    logic [7:0] r_ptr;
    logic       r_sda_oe, r_wr_en, r_busy;
    logic [7:0] r_wr_addr, r_wr_data;
`ifdef IIC_TARGET_READ_EN
    logic       r_rw;
    logic [6:0] r_tx;
`else
    logic       w_unused_rd;
    assign w_unused_rd = ^i_rd_data;
`endif

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_hit;
    logic [7:0] w_byte;

    assign w_scl_rise = r_scl_f & ~r_scl_d;
    assign w_scl_fall = ~r_scl_f & r_scl_d;
    assign w_start    = ~r_sda_f & r_sda_d & r_scl_f;
    assign w_stop     = r_sda_f & ~r_sda_d & r_scl_f;
    assign w_byte     = {r_shift, r_sda_f};
    assign w_addr_hit = (w_byte[7:1] == SLAVE_ADDR);

    assign o_sda_oe  = r_sda_oe;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_rd_addr = r_ptr;
    assign o_busy    = r_busy;

    // Synchronize both bus lines and accept a level only after FILTER_LEN equal samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_cnt  <= 4'd0;
            r_sda_cnt  <= 4'd0;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_d    <= r_scl_f;
            r_sda_d    <= r_sda_f;
            if (r_scl_sync[1] != r_scl_f) begin
                if (r_scl_cnt == FILT_MAX) begin
                    r_scl_f   <= r_scl_sync[1];
                    r_scl_cnt <= 4'd0;
                end else begin
                    r_scl_cnt <= r_scl_cnt + 4'd1;
                end
            end else begin
                r_scl_cnt <= 4'd0;
            end
            if (r_sda_sync[1] != r_sda_f) begin
                if (r_sda_cnt == FILT_MAX) begin
                    r_sda_f   <= r_sda_sync[1];
                    r_sda_cnt <= 4'd0;
                end else begin
                    r_sda_cnt <= r_sda_cnt + 4'd1;
                end
            end else begin
                r_sda_cnt <= 4'd0;
            end
        end
    end

    // Protocol FSM: START/STOP override everything, bits sampled on SCL rise, SDA driven on SCL fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bitcnt  <= 3'd0;
            r_shift   <= 7'd0;
            r_ack_on  <= 1'b0;
            r_ptr     <= 8'd0;
            r_sda_oe  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 8'd0;
            r_busy    <= 1'b0;
`ifdef IIC_TARGET_READ_EN
            r_rw      <= 1'b0;
            r_tx      <= 7'd0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= 3'd0;
                r_sda_oe <= 1'b0;
                r_ack_on <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_ack_on <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_IGNORE: r_sda_oe <= 1'b0;
                    S_ADDR: if (w_scl_rise) begin
                        r_shift <= w_byte[6:0];
                        if (r_bitcnt == 3'd7) begin
                            r_bitcnt <= 3'd0;
                            if (w_addr_hit && !w_byte[0]) begin
`ifdef IIC_TARGET_READ_EN
                                r_rw    <= 1'b0;
`endif
                                r_busy  <= 1'b1;
                                r_state <= S_ADDR_ACK;
`ifdef IIC_TARGET_READ_EN
                            end else if (w_addr_hit && w_byte[0]) begin
                                r_rw    <= 1'b1;
                                r_busy  <= 1'b1;
                                r_state <= S_ADDR_ACK;
`endif
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_IGNORE;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    S_ADDR_ACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            r_sda_oe <= 1'b1;
                            r_ack_on <= 1'b1;
                        end else begin
                            r_ack_on <= 1'b0;
                            r_bitcnt <= 3'd0;
`ifdef IIC_TARGET_READ_EN
                            if (r_rw) begin
                                r_tx     <= i_rd_data[6:0];
                                r_sda_oe <= ~i_rd_data[7];
                                r_state  <= S_RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_REG;
                            end
`else
                            r_sda_oe <= 1'b0;
                            r_state  <= S_REG;
`endif
                        end
                    end
                    S_REG: if (w_scl_rise) begin
                        r_shift <= w_byte[6:0];
                        if (r_bitcnt == 3'd7) begin
                            r_bitcnt <= 3'd0;
                            r_ptr    <= w_byte;
                            r_state  <= S_REG_ACK;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    S_WDATA: if (w_scl_rise) begin
                        r_shift <= w_byte[6:0];
                        if (r_bitcnt == 3'd7) begin
                            r_bitcnt  <= 3'd0;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_ptr;
                            r_wr_data <= w_byte;
                            r_ptr     <= r_ptr + 8'd1;
                            r_state   <= S_WDATA_ACK;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    S_REG_ACK, S_WDATA_ACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            r_sda_oe <= 1'b1;
                            r_ack_on <= 1'b1;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_ack_on <= 1'b0;
                            r_bitcnt <= 3'd0;
                            r_state  <= S_WDATA;
                        end
                    end
`ifdef IIC_TARGET_READ_EN
                    S_RDATA: if (w_scl_fall) begin
                        if (r_bitcnt == 3'd7) begin
                            r_sda_oe <= 1'b0;
                            r_ptr    <= r_ptr + 8'd1;
                            r_bitcnt <= 3'd0;
                            r_ack_on <= 1'b0;
                            r_state  <= S_RDATA_ACK;
                        end else begin
                            r_sda_oe <= ~r_tx[6];
                            r_tx     <= {r_tx[5:0], 1'b0};
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            if (r_sda_f) begin
                                r_state <= S_IGNORE;
                            end else begin
                                r_ack_on <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_on) begin
                            r_ack_on <= 1'b0;
                            r_bitcnt <= 3'd0;
                            r_tx     <= i_rd_data[6:0];
                            r_sda_oe <= ~i_rd_data[7];
                            r_state  <= S_RDATA;
                        end else begin
                            r_sda_oe <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
